vga_pixel_sink: RTL and testbench
=================================

// Module: vga_pixel_sink
// PURPOSE
//  Receiving end of the pixel-plot interface driven by the drawing FSMs (clear-screen sweep, Bresenham line).
//  - Write side: captures each plot request (x, y, colour) into an internal 160x120x3 frame buffer.
//  - Scan-out side: reads the frame buffer back continuously and drives 640x480@60 VGA timing.
//  - Each stored pixel is replicated over a 4x4 block of screen pixels.
// PARAMETERS
//  CLK_DIV   2    clk cycles per VGA pixel (50 MHz clk -> 25 MHz pixel rate); legal values >= 1
//  FB_W      160  frame-buffer columns
//  FB_H      120  frame-buffer rows
//  H_ACTIVE  640  horizontal visible pixels (must equal 4*FB_W)
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   horizontal sync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  vertical visible lines (must equal 4*FB_H)
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vertical sync width, lines
//  V_BP      33   vertical back porch, lines
// PORTS
//  clk          in   1   single system clock; all logic on its rising edge
//  reset        in   1   asynchronous, active-high reset
//  plot         in   1   write strobe; one pixel is written per cycle in which it is high
//  x            in   9   pixel column, 0..FB_W-1
//  y            in   9   pixel row, 0..FB_H-1
//  colour       in   3   {R,G,B}, one bit each
//  plot_drop    out  1   1-cycle pulse: the plot in the previous cycle was out of range and was discarded
//  vga_r        out  8   red channel, {8{colour[2]}} in the visible region, else 0
//  vga_g        out  8   green channel, {8{colour[1]}}
//  vga_b        out  8   blue channel, {8{colour[0]}}
//  vga_hs       out  1   horizontal sync, active-low
//  vga_vs       out  1   vertical sync, active-low
//  vga_blank_n  out  1   1 inside the visible region
//  pix_tick     out  1   1-clk pulse, once every CLK_DIV clocks; marks a VGA pixel slot
//  frame_start  out  1   1-clk pulse on the pix_tick at which h_cnt=0 and v_cnt=0
// BEHAVIOUR
//  Reset values:
//  - All outputs 0, except vga_hs=1 and vga_vs=1.
//  - Divider and h_cnt/v_cnt return to 0.
//  - Frame-buffer contents are NOT cleared; the drawing FSM performs the clear sweep.
//  - Reset asserted mid-frame aborts the frame; scan restarts at h_cnt=0, v_cnt=0 after release.
//  Write path:
//  - No handshake; a plot is accepted every cycle, back-to-back.
//  - x>=FB_W or y>=FB_H: write suppressed, plot_drop=1 in the next cycle.
//  - Address = y*FB_W + x, 15 bits, 0..19199.
//  - Write is registered; the RAM is updated at the first rising edge after plot is sampled.
//  Divider and counters:
//  - The divider counts 0..CLK_DIV-1; pix_tick is high when it equals CLK_DIV-1.
//  - h_cnt runs 0..799 and advances only on pix_tick, wrapping 799->0.
//  - v_cnt increments when h_cnt wraps and itself wraps 524->0.
//  Horizontal region FSM (H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT), switching on pix_tick at:
//  - H_ACT  : h_cnt 0..639
//  - H_FP   : h_cnt 640..655
//  - H_SYNC : h_cnt 656..751
//  - H_BP   : h_cnt 752..799
//  Vertical region FSM, the same four regions over v_cnt:
//  - V_ACT  : 0..479
//  - V_FP   : 480..489
//  - V_SYNC : 490..491
//  - V_BP   : 492..524
//  - Changes state only when h_cnt wraps.
//  Read pipeline:
//  - Read address = (v_cnt>>2)*FB_W + (h_cnt>>2); RAM read latency is 1 clk.
//  - hs/vs/blank are delayed so all VGA outputs update together, one pix_tick after the counter value that produced them.
//  - Outputs hold their values between ticks.
//  - Visible = H_ACT && V_ACT; outside the visible region rgb is forced to 0.
//  Read/write collision (same address, same cycle): read-first; scan-out shows the old value and the new value on the next frame.
//  Arithmetic: y*FB_W is implemented as (y<<7)+(y<<5); no multiplier.
// TESTING
//  1. Reset, then run 2 frames -> frame_start period = 800*525*CLK_DIV = 840000 clk; hs low for 96 ticks starting at h=656; vs low for lines 490-491.
//  2. plot x=0,y=0,colour=3'b100 -> screen pixels (0..3, 0..3) have vga_r=8'hFF, g=b=0, blank_n=1; screen pixel (4,0) keeps the old value.
//  3. plot x=159,y=119,colour=3'b011 -> screen pixels (636..639, 476..479) show g=b=FF; pixel (640,479) has blank_n=0 and rgb=0.
//  4. plot x=160,y=5 then x=3,y=120 -> plot_drop pulses twice, one cycle after each plot; RAM is unchanged (read back through scan-out).
//  5. 19200-cycle back-to-back clear sweep with colour=0 concurrent with scan-out -> no plot dropped; next full frame is all rgb=0.
//  6. Assert reset at h=300,v=200 for 3 clk -> outputs return to reset values immediately; first frame_start comes 1 pix_tick after release; earlier RAM writes are still visible.

Source files
------------

// File: rtl/vga_pixel_sink.sv
// Pixel-plot sink: a 3-bit frame buffer written by the drawing FSMs and scanned
// out continuously as 640x480@60 VGA, each stored pixel shown as a 4x4 block.
module vga_pixel_sink #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned FB_W     = 160,
   parameter int unsigned FB_H     = 120,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       plot,
   input  logic [8:0] x,
   input  logic [8:0] y,
   input  logic [2:0] colour,
   output logic       plot_drop,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       pix_tick,
   output logic       frame_start
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned FB_DEPTH = FB_W * FB_H;
   localparam int unsigned AW       = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
   localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned HW       = $clog2(H_TOTAL);
   localparam int unsigned VW       = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_FP_END   = HW'(H_ACTIVE + H_FP - 1);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [HW-1:0] H_BP_END   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] V_FP_END   = VW'(V_ACTIVE + V_FP - 1);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [VW-1:0] V_BP_END   = VW'(V_TOTAL - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {REG_ACT, REG_FP, REG_SYNC, REG_BP} region_t;

   // row*FB_W + col as a sum of constant shifts (160 -> (row<<7)+(row<<5))
   function automatic logic [AW-1:0] fb_addr(input logic [8:0] col, input logic [8:0] row);
      logic [AW-1:0] acc;
      acc = AW'(col);
      for (int k = 0; k < 9; k++) begin
         if (FB_W[k]) acc = acc + (AW'(row) << k);
      end
      return acc;
   endfunction

   logic [2:0]    mem [FB_DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [2:0]    wr_data;
   logic [2:0]    rd_data;
   logic [AW-1:0] rd_addr;
   logic          in_range_c;

   logic [DW-1:0] div_q, div_nxt;
   logic          tick_nxt;
   logic [HW-1:0] h_cnt, h_nxt;
   logic [VW-1:0] v_cnt, v_nxt;
   logic          h_wrap;
   region_t       h_state, v_state;
   logic          visible_c;

   assign in_range_c = (x < 9'(FB_W)) && (y < 9'(FB_H));
   assign visible_c  = (h_state == REG_ACT) && (v_state == REG_ACT);

   // Plot capture: one cycle of registering before the RAM write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         plot_drop <= 1'b0;
      end else begin
         wr_en     <= plot && in_range_c;
         wr_addr   <= fb_addr(x, y);
         wr_data   <= colour;
         plot_drop <= plot && !in_range_c;
      end
   end

   // Next divider/counter values; the read address follows the next counters
   // so rd_data always holds the pixel for the current counter value
   always_comb begin
      div_nxt  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_nxt = (div_nxt == DIV_LAST);
      h_wrap   = pix_tick && (h_cnt == H_BP_END);
      h_nxt    = h_cnt;
      v_nxt    = v_cnt;
      if (pix_tick) h_nxt = h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap)   v_nxt = (v_cnt == V_BP_END) ? '0 : v_cnt + 1'b1;
      rd_addr = '0;
      if ((h_nxt <= H_ACT_END) && (v_nxt <= V_ACT_END))
         rd_addr = fb_addr(9'(h_nxt >> 2), 9'(v_nxt >> 2));
   end

   // Frame buffer, read-first on a same-address collision
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

   // Timing counters, region FSMs and the registered VGA outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q       <= '0;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         h_state     <= REG_ACT;
         v_state     <= REG_ACT;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
      end else begin
         div_q       <= div_nxt;
         pix_tick    <= tick_nxt;
         frame_start <= tick_nxt && (h_nxt == '0) && (v_nxt == '0);
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         if (pix_tick) begin
            case (h_state)
               REG_ACT:  if (h_cnt == H_ACT_END)  h_state <= REG_FP;
               REG_FP:   if (h_cnt == H_FP_END)   h_state <= REG_SYNC;
               REG_SYNC: if (h_cnt == H_SYNC_END) h_state <= REG_BP;
               REG_BP:   if (h_cnt == H_BP_END)   h_state <= REG_ACT;
            endcase
            vga_hs      <= (h_state != REG_SYNC);
            vga_vs      <= (v_state != REG_SYNC);
            vga_blank_n <= visible_c;
            vga_r       <= visible_c ? {8{rd_data[2]}} : 8'h00;
            vga_g       <= visible_c ? {8{rd_data[1]}} : 8'h00;
            vga_b       <= visible_c ? {8{rd_data[0]}} : 8'h00;
         end
         if (h_wrap) begin
            case (v_state)
               REG_ACT:  if (v_cnt == V_ACT_END)  v_state <= REG_FP;
               REG_FP:   if (v_cnt == V_FP_END)   v_state <= REG_SYNC;
               REG_SYNC: if (v_cnt == V_SYNC_END) v_state <= REG_BP;
               REG_BP:   if (v_cnt == V_BP_END)   v_state <= REG_ACT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Directed bench for vga_pixel_sink on a scaled-down raster (8x6 buffer,
// 40x30 screen) so whole frames can be captured and compared.
module tb_vga_pixel_sink;

   localparam int CD  = 2;
   localparam int FBW = 8;
   localparam int FBH = 6;
   localparam int HA  = 32;
   localparam int HFP = 2;
   localparam int HSY = 4;
   localparam int HBP = 2;
   localparam int VA  = 24;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 2;
   localparam int HT  = HA + HFP + HSY + HBP;
   localparam int VT  = VA + VFP + VSY + VBP;
   localparam int NT  = HT * VT;
   localparam int FRAME_CLK = NT * CD;

   logic       clk = 1'b0;
   logic       reset, plot;
   logic [8:0] x, y;
   logic [2:0] colour;
   logic       plot_drop;
   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, vga_blank_n, pix_tick, frame_start;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fs_cyc, fs_extra;

   logic [7:0] cap_r [NT];
   logic [7:0] cap_g [NT];
   logic [7:0] cap_b [NT];
   logic       cap_hs [NT];
   logic       cap_vs [NT];
   logic       cap_bl [NT];
   logic [2:0] mdl [FBW*FBH];

   vga_pixel_sink #(
      .CLK_DIV(CD), .FB_W(FBW), .FB_H(FBH),
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
      .plot_drop(plot_drop), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .pix_tick(pix_tick), .frame_start(frame_start)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int idx(int h, int v);
      return v * HT + h;
   endfunction

   function automatic bit m_blank(int h, int v);
      return (h < HA) && (v < VA);
   endfunction

   function automatic bit m_hs(int h);
      return !((h >= HA + HFP) && (h < HA + HFP + HSY));
   endfunction

   function automatic bit m_vs(int v);
      return !((v >= VA + VFP) && (v < VA + VFP + VSY));
   endfunction

   function automatic logic [23:0] exp_rgb(int h, int v);
      logic [2:0] c;
      if (!m_blank(h, v)) return 24'h0;
      c = mdl[(v / 4) * FBW + h / 4];
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

   // number of captured ticks that differ from the reference raster
   function automatic int frame_bad();
      int n = 0;
      for (int k = 0; k < NT; k++) begin
         if ({cap_r[k], cap_g[k], cap_b[k]} !== exp_rgb(k % HT, k / HT) ||
             cap_hs[k] !== m_hs(k % HT) || cap_vs[k] !== m_vs(k / HT) ||
             cap_bl[k] !== m_blank(k % HT, k / HT)) n++;
      end
      return n;
   endfunction

   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * CD + 4; i++) begin
         @(negedge clk);
         if (pix_tick === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < FRAME_CLK + 4 * CD + 8; i++) begin
         @(negedge clk);
         if (pix_tick === 1'b1 && frame_start === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   // Capture one frame: entry k holds the outputs produced by counter value k
   task automatic scan_frame(output bit ok);
      bit t;
      fs_extra = 0;
      wait_fs(ok);
      if (!ok) return;
      fs_cyc = cyc;
      for (int k = 0; k < NT; k++) begin
         if (k > 0) begin
            wait_tick(t);
            if (!t) begin ok = 1'b0; return; end
            if (frame_start === 1'b1) fs_extra++;
         end
         @(posedge clk);
         #1;
         cap_r[k] = vga_r;   cap_g[k] = vga_g;   cap_b[k] = vga_b;
         cap_hs[k] = vga_hs; cap_vs[k] = vga_vs; cap_bl[k] = vga_blank_n;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
         errors++; $display("FAIL reset_sync: hs=%b vs=%b, required 1 1", vga_hs, vga_vs);
      end
      checks++;
      if ({vga_r, vga_g, vga_b, vga_blank_n, pix_tick, frame_start, plot_drop} !== 28'h0) begin
         errors++; $display("FAIL reset_outputs: rgb=%h/%h/%h blank_n=%b tick=%b fs=%b drop=%b, required all 0",
                            vga_r, vga_g, vga_b, vga_blank_n, pix_tick, frame_start, plot_drop);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (pix_tick !== 1'b1 || frame_start !== 1'b1) begin
         errors++; $display("FAIL first_tick: tick=%b fs=%b, required 1 1", pix_tick, frame_start);
      end
      @(negedge clk);
      checks++;
      if (pix_tick !== 1'b0 || frame_start !== 1'b0) begin
         errors++; $display("FAIL tick_gap: tick=%b fs=%b, required 0 0", pix_tick, frame_start);
      end
   endtask

   task automatic test_timing();
      bit ok, ok2;
      int t0, bad, first_lo, lo_cnt, first_v, v_lo;
      scan_frame(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL timing_scan: timeout=1, required 0"); end
      t0 = fs_cyc;
      wait_fs(ok2);
      checks++;
      if (!ok2 || cyc - t0 != FRAME_CLK) begin
         errors++; $display("FAIL fs_period: got %0d clk (found=%b), required %0d", cyc - t0, ok2, FRAME_CLK);
      end
      checks++;
      if (fs_extra != 0) begin
         errors++; $display("FAIL fs_extra: %0d extra pulses, required 0", fs_extra);
      end
      first_lo = -1; lo_cnt = 0;
      for (int h = 0; h < HT; h++) begin
         if (cap_hs[idx(h, 0)] === 1'b0) begin
            lo_cnt++;
            if (first_lo < 0) first_lo = h;
         end
      end
      checks++;
      if (lo_cnt != HSY || first_lo != HA + HFP) begin
         errors++; $display("FAIL hs_pulse: %0d ticks from h=%0d, required %0d from h=%0d",
                            lo_cnt, first_lo, HSY, HA + HFP);
      end
      first_v = -1; v_lo = 0;
      for (int v = 0; v < VT; v++) begin
         if (cap_vs[idx(0, v)] === 1'b0) begin
            v_lo++;
            if (first_v < 0) first_v = v;
         end
      end
      checks++;
      if (v_lo != VSY || first_v != VA + VFP) begin
         errors++; $display("FAIL vs_pulse: %0d lines from v=%0d, required %0d from v=%0d",
                            v_lo, first_v, VSY, VA + VFP);
      end
      bad = 0;
      for (int k = 0; k < NT; k++) begin
         if (cap_hs[k] !== m_hs(k % HT) || cap_vs[k] !== m_vs(k / HT) ||
             cap_bl[k] !== m_blank(k % HT, k / HT)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL sync_blank_frame: %0d wrong ticks, required 0", bad);
      end
   endtask

   task automatic test_clear_sweep();
      bit ok;
      int drops, bad;
      wait_fs(ok);
      drops = 0;
      for (int i = 0; i < FBW * FBH; i++) begin
         plot = 1'b1; x = 9'(i % FBW); y = 9'(i / FBW); colour = 3'b000;
         @(negedge clk);
         if (plot_drop !== 1'b0) drops++;
      end
      plot = 1'b0;
      @(negedge clk);
      if (plot_drop !== 1'b0) drops++;
      for (int i = 0; i < FBW * FBH; i++) mdl[i] = 3'b000;
      checks++;
      if (!ok || drops != 0) begin
         errors++; $display("FAIL sweep_drops: %0d drops (sync=%b), required 0", drops, ok);
      end
      scan_frame(ok);
      bad = 0;
      for (int k = 0; k < NT; k++)
         if ({cap_r[k], cap_g[k], cap_b[k]} !== 24'h0) bad++;
      checks++;
      if (!ok || bad != 0) begin
         errors++; $display("FAIL sweep_black: %0d lit ticks (scan=%b), required 0", bad, ok);
      end
   endtask

   task automatic test_plot_origin();
      bit ok;
      int bad;
      wait_fs(ok);
      plot = 1'b1; x = 9'd0; y = 9'd0; colour = 3'b100;
      @(negedge clk);
      plot = 1'b0;
      mdl[0] = 3'b100;
      checks++;
      if (plot_drop !== 1'b0) begin
         errors++; $display("FAIL origin_drop: drop=%b, required 0", plot_drop);
      end
      scan_frame(ok);
      bad = 0;
      for (int v = 0; v < 4; v++)
         for (int h = 0; h < 4; h++)
            if ({cap_r[idx(h, v)], cap_g[idx(h, v)], cap_b[idx(h, v)]} !== 24'hFF0000 ||
                cap_bl[idx(h, v)] !== 1'b1) bad++;
      checks++;
      if (!ok || bad != 0) begin
         errors++; $display("FAIL origin_block: %0d wrong of 16 (scan=%b), required 0", bad, ok);
      end
      checks++;
      if ({cap_r[idx(4, 0)], cap_g[idx(4, 0)], cap_b[idx(4, 0)]} !== 24'h0) begin
         errors++; $display("FAIL origin_neighbour: rgb=%h%h%h, required 000000",
                            cap_r[idx(4, 0)], cap_g[idx(4, 0)], cap_b[idx(4, 0)]);
      end
      bad = frame_bad();
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL origin_frame: %0d wrong ticks, required 0", bad);
      end
   endtask

   task automatic test_plot_far_corner();
      bit ok;
      int bad;
      wait_fs(ok);
      plot = 1'b1; x = 9'(FBW - 1); y = 9'(FBH - 1); colour = 3'b011;
      @(negedge clk);
      plot = 1'b0;
      mdl[FBW * FBH - 1] = 3'b011;
      scan_frame(ok);
      bad = 0;
      for (int v = VA - 4; v < VA; v++)
         for (int h = HA - 4; h < HA; h++)
            if ({cap_r[idx(h, v)], cap_g[idx(h, v)], cap_b[idx(h, v)]} !== 24'h00FFFF ||
                cap_bl[idx(h, v)] !== 1'b1) bad++;
      checks++;
      if (!ok || bad != 0) begin
         errors++; $display("FAIL corner_block: %0d wrong of 16 (scan=%b), required 0", bad, ok);
      end
      checks++;
      if ({cap_bl[idx(HA, VA - 1)], cap_r[idx(HA, VA - 1)], cap_g[idx(HA, VA - 1)],
           cap_b[idx(HA, VA - 1)]} !== 25'h0) begin
         errors++; $display("FAIL corner_edge: blank_n=%b rgb=%h%h%h, required 0 000000",
                            cap_bl[idx(HA, VA - 1)], cap_r[idx(HA, VA - 1)],
                            cap_g[idx(HA, VA - 1)], cap_b[idx(HA, VA - 1)]);
      end
      bad = frame_bad();
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL corner_frame: %0d wrong ticks, required 0", bad);
      end
   endtask

   task automatic test_plot_drop();
      bit ok;
      int bad;
      wait_fs(ok);
      plot = 1'b1; x = 9'(FBW); y = 9'd2; colour = 3'b111;
      @(negedge clk);
      plot = 1'b0;
      checks++;
      if (plot_drop !== 1'b1) begin errors++; $display("FAIL drop_x: drop=%b, required 1", plot_drop); end
      @(negedge clk);
      checks++;
      if (plot_drop !== 1'b0) begin errors++; $display("FAIL drop_x_end: drop=%b, required 0", plot_drop); end
      plot = 1'b1; x = 9'd3; y = 9'(FBH); colour = 3'b111;
      @(negedge clk);
      plot = 1'b0;
      checks++;
      if (plot_drop !== 1'b1) begin errors++; $display("FAIL drop_y: drop=%b, required 1", plot_drop); end
      @(negedge clk);
      checks++;
      if (plot_drop !== 1'b0) begin errors++; $display("FAIL drop_y_end: drop=%b, required 0", plot_drop); end
      scan_frame(ok);
      checks++;
      if (!ok || {cap_r[idx(0, 12)], cap_g[idx(0, 12)], cap_b[idx(0, 12)]} !== 24'h0) begin
         errors++; $display("FAIL drop_alias: rgb=%h%h%h (scan=%b), required 000000",
                            cap_r[idx(0, 12)], cap_g[idx(0, 12)], cap_b[idx(0, 12)], ok);
      end
      bad = frame_bad();
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL drop_frame: %0d wrong ticks, required 0", bad);
      end
   endtask

   task automatic test_reset_midframe();
      bit ok, t;
      int rel, bad;
      wait_fs(ok);
      for (int i = 0; i < 10 * HT + 15; i++) begin
         wait_tick(t);
         if (!t) ok = 1'b0;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL mid_position: timeout=1, required 0"); end
      reset = 1'b1;
      #1;
      checks++;
      if ({vga_hs, vga_vs} !== 2'b11 ||
          {vga_r, vga_g, vga_b, vga_blank_n, pix_tick, frame_start, plot_drop} !== 28'h0) begin
         errors++; $display("FAIL mid_reset_outputs: hs=%b vs=%b rgb=%h/%h/%h blank_n=%b tick=%b fs=%b, required 1 1 0 0 0 0 0 0",
                            vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_blank_n, pix_tick, frame_start);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      scan_frame(ok);
      checks++;
      if (!ok || fs_cyc - rel != 1) begin
         errors++; $display("FAIL restart_latency: %0d clk (scan=%b), required 1", fs_cyc - rel, ok);
      end
      checks++;
      if (cap_r[idx(0, 0)] !== 8'hFF || cap_r[idx(3, 3)] !== 8'hFF ||
          {cap_g[idx(HA - 1, VA - 1)], cap_b[idx(HA - 1, VA - 1)]} !== 16'hFFFF) begin
         errors++; $display("FAIL ram_kept: r00=%h r33=%h gb_corner=%h%h, required FF FF FFFF",
                            cap_r[idx(0, 0)], cap_r[idx(3, 3)],
                            cap_g[idx(HA - 1, VA - 1)], cap_b[idx(HA - 1, VA - 1)]);
      end
      bad = frame_bad();
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL restart_frame: %0d wrong ticks, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_clear_sweep();
      test_plot_origin();
      test_plot_far_corner();
      test_plot_drop();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
